seq_alu_unit: RTL and testbench

//  Parametrised ALU with a registered result, a 4-bit status register and multicycle ops.

---
 rtl/seq_alu_unit.sv | 180 ++++++++++++++++++
 tb/tb_seq_alu_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_unit.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative MUL and shifts,
// with a start/busy/done handshake, registered result and {V,N,Z,C} status flags.
module seq_alu_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       funsel,
    input  logic             sflag,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic [3:0]       flags
);
    localparam int CNTW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_INT = ~MIN_INT;
    localparam logic [CNTW-1:0]  CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_nxt;
    logic [3:0]         op;
    logic               sf;
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] p;
    logic [CNTW-1:0]    cnt;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   sc_z;
    logic               sc_c, sc_v;
    logic               is_iter;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] p_nxt;
    logic [WIDTH-1:0]   a_nxt;
    logic               sh_out;
    logic               accept, load_z, fin_sf, c_val, v_val;
    logic [WIDTH-1:0]   z_val;

    // Single-cycle results, computed straight from the operand buses.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        add_sum = '0;
        sc_z    = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        case (funsel)
            4'd1: sc_z = x;
            4'd2: begin
                add_sum = {1'b0, x} + {1'b0, y};
                sc_z    = add_sum[WIDTH-1:0];
                sc_c    = add_sum[WIDTH];
                sc_v    = (x[WIDTH-1] == y[WIDTH-1]) && (sc_z[WIDTH-1] != x[WIDTH-1]);
            end
            4'd3: begin
                sc_z = -x;
                sc_v = (x == MIN_INT);
            end
            4'd4: sc_z = x | y;
            4'd5: sc_z = ~x;
            4'd6: begin
                add_sum = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
                sc_z    = add_sum[WIDTH-1:0];
                sc_c    = add_sum[WIDTH];
                sc_v    = (x == MAX_INT);
            end
            4'd7: begin
                sc_z = x - {{(WIDTH-1){1'b0}}, 1'b1};
                sc_v = (x == MIN_INT);
            end
            4'd9, 4'd10, 4'd11: sc_z = x;
            default: sc_z = '0;
        endcase
    end

    assign is_iter = (funsel == 4'd8) ||
                     ((funsel == 4'd9 || funsel == 4'd10 || funsel == 4'd11) &&
                      (y[CNTW-1:0] != '0));

    // One shift-add multiply step on p, and one single-bit shift on a.
    always_comb begin
        mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
        p_nxt   = {mul_sum, p[WIDTH-1:1]};
        a_nxt   = a;
        sh_out  = 1'b0;
        case (op)
            4'd9: begin
                a_nxt  = {a[WIDTH-2:0], 1'b0};
                sh_out = a[WIDTH-1];
            end
            4'd10: begin
                a_nxt  = {1'b0, a[WIDTH-1:1]};
                sh_out = a[0];
            end
            4'd11: begin
                a_nxt  = {a[WIDTH-1], a[WIDTH-1:1]};
                sh_out = a[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_z    = 1'b0;
        fin_sf    = sf;
        z_val     = sc_z;
        c_val     = sc_c;
        v_val     = sc_v;
        case (state)
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = FIN;
                    load_z    = 1'b1;
                    v_val     = 1'b0;
                    if (op == 4'd8) begin
                        z_val = p_nxt[WIDTH-1:0];
                        c_val = |p_nxt[2*WIDTH-1:WIDTH];
                    end else begin
                        z_val = a_nxt;
                        c_val = sh_out;
                    end
                end
            end
            default: begin
                // IDLE and FIN accept a new op identically, giving back-to-back issue.
                if (start) begin
                    accept = 1'b1;
                    if (is_iter) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = FIN;
                        load_z    = 1'b1;
                        fin_sf    = sflag;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            z     <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            if (load_z)
                z <= z_val;
            if (load_z && fin_sf)
                flags <= {v_val, z_val[WIDTH-1], (z_val == '0), c_val};
        end
    end

    // NOTE: the operand/iteration registers need no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op  <= funsel;
            sf  <= sflag;
            a   <= x;
            p   <= {{WIDTH{1'b0}}, y};
            cnt <= (funsel == 4'd8) ? CNTW'(WIDTH - 1) : (y[CNTW-1:0] - CNT_ONE);
        end else if (state == RUN) begin
            a   <= a_nxt;
            p   <= p_nxt;
            cnt <= cnt - CNT_ONE;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

endmodule

// File: tb/tb_seq_alu_unit.sv
// Scoreboard bench for seq_alu_unit: directed cases plus random ops checked against an
// arithmetic reference model, including completion cycle, flag hold and reset abort.
module tb_seq_alu_unit;
    localparam int W  = 16;
    localparam int CW = 4;
    localparam longint MOD  = longint'(1) << W;
    localparam longint MAXP = (longint'(1) << (W - 1)) - 1;
    localparam longint MINN = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   funsel = '0;
    logic         sflag = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         busy, done;
    logic [W-1:0] z;
    logic [3:0]   flags;

    seq_alu_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funsel(funsel), .sflag(sflag),
        .x(x), .y(y), .busy(busy), .done(done), .z(z), .flags(flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] z;
        logic [3:0]   f;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           free_edge = 0;
    logic [3:0]   flags_m = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    task automatic model(input logic [3:0] fs, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         output logic [W-1:0] r, output logic c, output logic v, output int lat);
        longint xs, ys, sx, sy, t;
        int k;
        xs = longint'(xv);
        ys = longint'(yv);
        sx = xv[W-1] ? xs - MOD : xs;
        sy = yv[W-1] ? ys - MOD : ys;
        t = 0; c = 1'b0; v = 1'b0; lat = 1;
        k = int'(ys % (longint'(1) << CW));
        case (fs)
            4'd1: t = xs;
            4'd2: begin t = xs + ys; c = (t >= MOD); v = (sx + sy > MAXP) || (sx + sy < MINN); end
            4'd3: begin t = (MOD - xs) % MOD; v = (-sx > MAXP); end
            4'd4: t = longint'(xv | yv);
            4'd5: t = longint'(~xv);
            4'd6: begin t = xs + 1; c = (t >= MOD); v = (sx + 1 > MAXP); end
            4'd7: begin t = (xs + MOD - 1) % MOD; v = (sx - 1 < MINN); end
            4'd8: begin t = xs * ys; c = ((t / MOD) != 0); lat = W + 1; end
            4'd9: begin
                t = xs << k;
                c = (k != 0) && (((xs >> (W - k)) & 1) != 0);
                lat = k + 1;
            end
            4'd10: begin
                t = xs >> k;
                c = (k != 0) && (((xs >> (k - 1)) & 1) != 0);
                lat = k + 1;
            end
            4'd11: begin
                t = sx >>> k;
                c = (k != 0) && (((xs >> (k - 1)) & 1) != 0);
                lat = k + 1;
            end
            default: t = 0;
        endcase
        t = ((t % MOD) + MOD) % MOD;
        r = t[W-1:0];
    endtask

    // Called at a negedge; returns at the negedge following acceptance. While the DUT is
    // still busy in the model's view, random start pulses are driven that must be ignored.
    task automatic issue(input logic [3:0] fs, input logic sf, input logic [W-1:0] xv, input logic [W-1:0] yv);
        logic [W-1:0] r;
        logic c, v;
        int lat, n;
        exp_t e;
        while (cyc + 1 < free_edge) begin
            start  = ($urandom_range(0, 2) == 0);
            funsel = 4'($urandom);
            sflag  = 1'($urandom);
            x      = W'($urandom);
            y      = W'($urandom);
            @(negedge clk);
        end
        start = 1'b1; funsel = fs; sflag = sf; x = xv; y = yv;
        model(fs, xv, yv, r, c, v, lat);
        if (sf)
            flags_m = {v, r[W-1], (r == '0), c};
        n = cyc + 1;
        e.z = r; e.f = flags_m; e.cyc = n + lat - 1;
        sb.push_back(e);
        free_edge = n + lat;
        @(negedge clk);
        start = 1'b0;
        x = W'($urandom);
        y = W'($urandom);
    endtask

    // Monitor: compares every completion against the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("z", 64'(z), 64'(e.z));
                    check("flags", 64'(flags), 64'(e.f));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (busy && sb.size() == 0) begin
                check("busy_without_op", 64'(busy), 64'(0));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_z", 64'(z), 64'(0));
        check("reset_flags", 64'(flags), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        reset = 1'b0;
        free_edge = cyc + 1;

        // Directed cases.
        issue(4'd2, 1'b1, 16'hFFFF, 16'h0001);
        issue(4'd8, 1'b1, 16'h00FF, 16'h0101);
        issue(4'd8, 1'b1, 16'h8000, 16'h8000);
        issue(4'd11, 1'b1, 16'h8000, 16'h0003);
        issue(4'd11, 1'b1, 16'h8000, 16'h0000);
        issue(4'd9, 1'b1, 16'h8001, 16'h000F);
        issue(4'd10, 1'b1, 16'h0003, 16'h0001);
        issue(4'd6, 1'b1, 16'h7FFF, 16'h0000);
        issue(4'd4, 1'b0, 16'h1234, 16'h0F0F);
        issue(4'd3, 1'b1, 16'h8000, 16'h0000);
        issue(4'd7, 1'b1, 16'h8000, 16'h0000);
        issue(4'd13, 1'b1, 16'hFFFF, 16'hFFFF);

        // Reset in the middle of a multiply: aborted, no completion ever appears.
        issue(4'd8, 1'b1, 16'h1234, 16'h5678);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        flags_m = '0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_z", 64'(z), 64'(0));
        check("abort_flags", 64'(flags), 64'(0));
        reset = 1'b0;
        free_edge = cyc + 1;

        // Random ops with random idle gaps.
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom), 1'($urandom), W'($urandom), W'($urandom));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        for (int i = 0; i < 200 && sb.size() > 0; i++)
            @(negedge clk);
        check("drain_pending", 64'(sb.size()), 64'(0));
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
